// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the pipelined CPU datapath: default widths,
// forwarding-select encodings and a constant log2 helper.
package cpu_pipe_pkg;

    localparam int unsigned WORD_SIZE = 32;

    typedef enum logic [1:0] {
        FWD_RF    = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2,
        FWD_IMM   = 2'd3
    } fwd_sel_e;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Select width for an N-way selector, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned num);
        return (clog2(num) < 1) ? 1 : clog2(num);
    endfunction

endpackage

// File: rtl/pipe_mux_n_if.sv
// Bus between a producer and the registered N-way selector: packed channels,
// select/valid/stall/flush in, last-stage data/valid/error out.
interface pipe_mux_n_if
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned SIZE = WORD_SIZE,
    parameter int unsigned NUM  = 4
);
    localparam int unsigned SEL_W = sel_width(NUM);

    logic [NUM*SIZE-1:0] data_i;
    logic [SEL_W-1:0]    select_i;
    logic                valid_i;
    logic                stall_i;
    logic                flush_i;
    logic [SIZE-1:0]     data_o;
    logic                valid_o;
    logic                sel_err_o;

    modport master (
        output data_i, select_i, valid_i, stall_i, flush_i,
        input  data_o, valid_o, sel_err_o
    );

    modport slave (
        input  data_i, select_i, valid_i, stall_i, flush_i,
        output data_o, valid_o, sel_err_o
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline register with flush (clear to bubble) taking priority over
// stall (hold), and asynchronous active-low reset.
module pipe_stage_reg #(
    parameter int unsigned WIDTH = 34
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            q_o <= '0;
        end else if (flush_i) begin
            q_o <= '0;
        end else if (!stall_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/pipe_mux_n.sv
// Registered N-input selector for forwarding paths: selects one channel,
// tags valid and out-of-range select, and pipelines the result DEPTH stages.
module pipe_mux_n
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned SIZE  = WORD_SIZE,
    parameter int unsigned NUM   = 4,
    parameter int unsigned DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    pipe_mux_n_if.slave  bus
);

    localparam int unsigned STAGE_W = SIZE + 2;

    logic [SIZE-1:0]    cap_data;
    logic               cap_err;
    logic [STAGE_W-1:0] stage_d [DEPTH];
    logic [STAGE_W-1:0] stage_q [DEPTH];

    // Invalid samples and out-of-range selects both capture zero data.
    always_comb begin
        cap_data = '0;
        if (bus.valid_i) begin
            for (int unsigned k = 0; k < NUM; k++) begin
                if (32'(bus.select_i) == k) begin
                    cap_data = bus.data_i[k*SIZE +: SIZE];
                end
            end
        end
    end

    assign cap_err    = bus.valid_i && (32'(bus.select_i) >= NUM);
    assign stage_d[0] = {cap_err, bus.valid_i, cap_data};

    for (genvar g = 1; g < DEPTH; g++) begin : g_link
        assign stage_d[g] = stage_q[g-1];
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        pipe_stage_reg #(
            .WIDTH (STAGE_W)
        ) u_stage (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .stall_i (bus.stall_i),
            .flush_i (bus.flush_i),
            .d_i     (stage_d[g]),
            .q_o     (stage_q[g])
        );
    end

    assign bus.data_o    = stage_q[DEPTH-1][SIZE-1:0];
    assign bus.valid_o   = stage_q[DEPTH-1][SIZE];
    assign bus.sel_err_o = stage_q[DEPTH-1][SIZE+1];

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n: three instances (4ch/depth3, 4ch/depth2, 3ch/depth2)
// driven by directed steps then random traffic, checked against a history model.
module tb_pipe_mux_n;

    typedef struct packed {
        logic        e;
        logic        v;
        logic [31:0] d;
    } smp_t;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pipe_mux_n_if #(.SIZE(32), .NUM(4)) ia ();
    pipe_mux_n_if #(.SIZE(32), .NUM(4)) ib ();
    pipe_mux_n_if #(.SIZE(32), .NUM(3)) ic ();

    pipe_mux_n #(.SIZE(32), .NUM(4), .DEPTH(3)) u_a (.clk_i(clk), .rst_i(rst_n), .bus(ia));
    pipe_mux_n #(.SIZE(32), .NUM(4), .DEPTH(2)) u_b (.clk_i(clk), .rst_i(rst_n), .bus(ib));
    pipe_mux_n #(.SIZE(32), .NUM(3), .DEPTH(2)) u_c (.clk_i(clk), .rst_i(rst_n), .bus(ic));

    logic [127:0] din [3];
    logic [1:0]   sel [3];
    logic         vin [3];
    logic         st  [3];
    logic         fl  [3];

    // Model: every advancing edge appends the captured sample to a history;
    // the output is the sample from DEPTH advances ago unless a flush/reset
    // happened more recently than that.
    smp_t        hist  [3][4096];
    int unsigned n_adv [3];
    int unsigned epoch [3];

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    function automatic int unsigned dep_of(input int i);
        return (i == 0) ? 3 : 2;
    endfunction

    function automatic int unsigned num_of(input int i);
        return (i == 2) ? 3 : 4;
    endfunction

    function automatic smp_t capture(input logic [127:0] d, input logic [1:0] s,
                                     input logic v, input int unsigned num);
        smp_t        r;
        logic [31:0] ch [4];
        for (int k = 0; k < 4; k++) ch[k] = d[k*32 +: 32];
        r   = '0;
        r.v = v;
        r.e = v && (32'(s) >= num);
        if (v && (32'(s) < num)) r.d = ch[s];
        return r;
    endfunction

    function automatic smp_t expected(input int i);
        if (n_adv[i] - epoch[i] >= dep_of(i)) return hist[i][n_adv[i] - dep_of(i)];
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        smp_t e;
        e = expected(0);
        chk("a.data",  ia.data_o,             e.d);
        chk("a.valid", 32'(ia.valid_o),       32'(e.v));
        chk("a.err",   32'(ia.sel_err_o),     32'(e.e));
        e = expected(1);
        chk("b.data",  ib.data_o,             e.d);
        chk("b.valid", 32'(ib.valid_o),       32'(e.v));
        chk("b.err",   32'(ib.sel_err_o),     32'(e.e));
        e = expected(2);
        chk("c.data",  ic.data_o,             e.d);
        chk("c.valid", 32'(ic.valid_o),       32'(e.v));
        chk("c.err",   32'(ic.sel_err_o),     32'(e.e));
    endtask

    task automatic drive();
        ia.data_i = din[0];       ia.select_i = sel[0]; ia.valid_i = vin[0];
        ia.stall_i = st[0];       ia.flush_i = fl[0];
        ib.data_i = din[1];       ib.select_i = sel[1]; ib.valid_i = vin[1];
        ib.stall_i = st[1];       ib.flush_i = fl[1];
        ic.data_i = din[2][95:0]; ic.select_i = sel[2]; ic.valid_i = vin[2];
        ic.stall_i = st[2];       ic.flush_i = fl[2];
    endtask

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            din[i] = '0; sel[i] = '0; vin[i] = 1'b0; st[i] = 1'b0; fl[i] = 1'b0;
        end
    endtask

    task automatic tick();
        drive();
        @(posedge clk);
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (fl[i]) begin
                    epoch[i] = n_adv[i];
                end else if (!st[i]) begin
                    hist[i][n_adv[i]] = capture(din[i], sel[i], vin[i], num_of(i));
                    n_adv[i]++;
                end
            end
        end
        #1;
        check_all();
    endtask

    // Asserts reset between edges and checks outputs before any edge occurs.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) epoch[i] = n_adv[i];
        chk("rst.b_data_now",  ib.data_o,         32'h0);
        chk("rst.b_valid_now", 32'(ib.valid_o),   32'h0);
        chk("rst.b_err_now",   32'(ib.sel_err_o), 32'h0);
        check_all();
        tick();
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            n_adv[i] = 0;
            epoch[i] = 0;
        end
        idle_all();
        drive();
        rst_n = 1'b0;
        #2;
        check_all();
        #10;
        rst_n = 1'b1;

        // Streaming 0x11..0x44 through the depth-3 instance.
        din[0] = {32'h44, 32'h33, 32'h22, 32'h11};
        vin[0] = 1'b1;
        for (int s = 0; s < 4; s++) begin
            sel[0] = 2'(s);
            tick();
        end
        chk("stream.data4", ia.data_o, 32'h22);

        // Stall with a different input presented; output must not move.
        st[0] = 1'b1; sel[0] = 2'd0; din[0][31:0] = 32'hDEAD_BEEF;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall.data",  ia.data_o,       32'h22);
            chk("stall.valid", 32'(ia.valid_o), 32'h1);
        end
        st[0] = 1'b0; vin[0] = 1'b0;
        tick(); chk("stream.data5", ia.data_o, 32'h33);
        tick(); chk("stream.data6", ia.data_o, 32'h44);
        tick(); chk("stream.drain", 32'(ia.valid_o), 32'h0);

        // Fill, then flush together with stall.
        vin[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din[0] = {$urandom, $urandom, $urandom, $urandom};
            sel[0] = 2'($urandom_range(0, 3));
            tick();
        end
        fl[0] = 1'b1; st[0] = 1'b1;
        tick();
        chk("flush.valid", 32'(ia.valid_o), 32'h0);
        chk("flush.data",  ia.data_o,       32'h0);
        fl[0] = 1'b0; st[0] = 1'b0; vin[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("flush.empty", 32'(ia.valid_o), 32'h0);
        end

        // Reset mid-stream on the depth-2 instance, then a first sample.
        vin[1] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            din[1] = {$urandom, $urandom, $urandom, $urandom};
            sel[1] = 2'($urandom_range(0, 3));
            tick();
        end
        async_reset();
        din[1] = '0; din[1][95:64] = 32'hCAFE_F00D; sel[1] = 2'd2; vin[1] = 1'b1;
        tick();
        chk("rst.first_edge_valid", 32'(ib.valid_o), 32'h0);
        vin[1] = 1'b0;
        tick();
        chk("rst.sample_data",  ib.data_o,       32'hCAFE_F00D);
        chk("rst.sample_valid", 32'(ib.valid_o), 32'h1);

        // Out-of-range select on the 3-channel instance.
        din[2] = {$urandom, $urandom, $urandom, $urandom};
        sel[2] = 2'd3; vin[2] = 1'b1;
        tick();
        vin[2] = 1'b0;
        tick();
        chk("oor.data",  ic.data_o,         32'h0);
        chk("oor.valid", 32'(ic.valid_o),   32'h1);
        chk("oor.err",   32'(ic.sel_err_o), 32'h1);
        tick(); tick();
        chk("oor.novalid_err", 32'(ic.sel_err_o), 32'h0);

        // Invalid input carries no data.
        din[2] = '0; din[2][63:32] = 32'h0000_FFFF; sel[2] = 2'd1; vin[2] = 1'b0;
        tick(); tick();
        chk("inval.data",  ic.data_o,       32'h0);
        chk("inval.valid", 32'(ic.valid_o), 32'h0);

        // Random traffic on all instances, with one mid-run async reset.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 3; i++) begin
                din[i] = {$urandom, $urandom, $urandom, $urandom};
                sel[i] = 2'($urandom_range(0, 3));
                vin[i] = ($urandom_range(0, 3) != 0);
                st[i]  = ($urandom_range(0, 5) == 0);
                fl[i]  = ($urandom_range(0, 15) == 0);
            end
            if (n == 200) async_reset();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
- Parametrised N-input, registered selector for the pipelined-with-forwarding CPU.
- Successor to the plain 2-input combinational data selector. Used on forwarding paths (ALU operand select among RF / EX-MEM / MEM-WB / immediate) where the selected value must be pipelined.
- Adds channel count, pipeline depth, valid tracking, stall (hold), flush (bubble) and out-of-range select detection.

Parameters:
- SIZE, 32, data width of each input channel and of the output.
- NUM, 4, number of input channels; legal range 2..16.
- DEPTH, 1, number of register stages between input and output; legal range 1..4.
- SEL_W, derived localparam = clog2(NUM) (minimum 1), select width; not overridable.

Ports:
- clk_i  input  1  rising-edge clock.
- rst_i  input  1  asynchronous, active-low reset.
- data_i  input  NUM*SIZE  packed channels; channel k occupies bits [k*SIZE +: SIZE].
- select_i  input  SEL_W  binary channel index.
- valid_i  input  1  input sample is meaningful.
- stall_i  input  1  hold every stage (no advance).
- flush_i  input  1  clear every stage to a bubble.
- data_o  output  SIZE  data from last stage.
- valid_o  output  1  valid from last stage.
- sel_err_o  output  1  last-stage entry was captured with select_i >= NUM.

Behaviour:
- One clock, one reset: clk_i and rst_i. Reset is asynchronous and active-low.
- While rst_i=0, every stage is cleared: data=0, valid=0, err=0. So data_o=0, valid_o=0 and sel_err_o=0 immediately, independent of clk_i.
- Stage-0 capture value:
  - Data = channel[select_i] when valid_i=1 and select_i<NUM; otherwise 0.
  - Err = valid_i AND (select_i >= NUM).
  - Valid = valid_i.
- Per rising edge, in priority order:
  1. flush_i=1: all stages get data=0, valid=0, err=0. The same-cycle input is discarded, and flush overrides stall.
  2. stall_i=1 (no flush): all stages hold their values. The input is not captured.
  3. Otherwise: stage0 takes the capture value and stage k takes stage k-1, for k=1..DEPTH-1.
- Latency is exactly DEPTH un-stalled edges from input to output. Throughput is one sample per cycle when not stalled.
- Outputs are driven only from last-stage registers; there is no combinational path from any input to any output.
- When NUM is a power of two, select_i>=NUM cannot occur and sel_err_o stays 0.
- Reset deasserted mid-stream: the pipeline restarts empty. The first valid_o appears DEPTH edges after the first captured valid_i.
- Stall held for any number of cycles: the output is stable and bit-identical throughout.
- Simultaneous valid_i and stall_i: the sample is dropped. Upstream must hold valid_i and data while stalled; this block does not buffer.

Decomposition:
- Shared package cpu_pipe_pkg holds:
  - clog2 constant function.
  - Default widths (WORD_SIZE=32).
  - Forwarding select encodings FWD_RF=0, FWD_EXMEM=1, FWD_MEMWB=2, FWD_IMM=3.
- One sub-module, pipe_stage_reg (SIZE+2 bits wide, with stall/flush/async active-low reset), instantiated DEPTH times via generate.
- The selection logic itself stays inline.

Test Plan:
- Reset: with rst_i=0 asserted mid-stream and DEPTH=2 -> data_o=0, valid_o=0, sel_err_o=0 immediately, without waiting for a clock edge. After release, a sample on sel=2 with channel2=0xCAFEF00D, valid=1 -> data_o=0xCAFEF00D, valid_o=1 exactly 2 edges later.
- Streaming: NUM=4, DEPTH=3, channels = 0x11, 0x22, 0x33, 0x44; sel sequence 0,1,2,3 with valid=1 on consecutive cycles -> data_o shows 0x11, 0x22, 0x33, 0x44 on cycles 3-6, with valid_o=1 throughout.
- Stall: stall_i=1 for 5 cycles while 0x22 is at the output -> data_o=0x22 and valid_o=1 on all 5 cycles. The input presented during the stall never appears at the output.
- Flush: flush_i=1 together with stall_i=1 while the pipeline is full -> next edge gives valid_o=0 and data_o=0. The pipeline stays empty for DEPTH cycles unless new valid input arrives.
- Out-of-range select: NUM=3, sel=3, valid=1 -> after DEPTH edges, data_o=0, valid_o=1, sel_err_o=1. The same sel with valid=0 -> sel_err_o=0.
- Invalid input: valid_i=0, sel=1, channel1=0xFFFF -> data_o=0 and valid_o=0 after the latency.
